// File: rtl/motion_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : motion_step_scheduler
//  Purpose  : Per-frame speed-accumulator scheduler that walks every object
//             slot and issues one-step move requests over valid/ready.
//  Revision : 1.0
// ============================================================================
module motion_step_scheduler #(
    parameter  int NUM_OBJ   = 4,
    parameter  int SPEED_W   = 10,
    parameter  int ACCEL     = 4,
    parameter  int DECEL     = 1,
    parameter  int SPEED_MAX = 1020,
    localparam int IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic [NUM_OBJ-1:0]           thrust,
    input  logic [NUM_OBJ-1:0]           obj_active,
    output logic                         upd_valid,
    output logic [IDX_W-1:0]             upd_idx,
    input  logic                         upd_ready,
    output logic [NUM_OBJ*SPEED_W-1:0]   speed_flat,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]   C_LAST_IDX  = IDX_W'(NUM_OBJ - 1);
    localparam logic [SPEED_W:0]   C_SPEED_MAX = (SPEED_W + 1)'(SPEED_MAX);
    localparam logic [SPEED_W:0]   C_ACCEL     = (SPEED_W + 1)'(ACCEL);
    localparam logic [SPEED_W-1:0] C_DECEL     = SPEED_W'(DECEL);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_OBJ-1:0]   thrust_snap_q, thrust_snap_d;
    logic [NUM_OBJ-1:0]   active_snap_q, active_snap_d;
    logic [SPEED_W-1:0]   speed_q [NUM_OBJ];
    logic [SPEED_W-1:0]   speed_d [NUM_OBJ];
    logic [SPEED_W-1:0]   acc_q   [NUM_OBJ];
    logic [SPEED_W-1:0]   acc_d   [NUM_OBJ];
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic [SPEED_W-1:0]   w_cur_speed;
    logic [SPEED_W:0]     w_inc;
    logic [SPEED_W-1:0]   w_speed_new;
    logic [SPEED_W:0]     w_sum;
    logic                 w_step;
    logic                 w_last;

    // Slot arithmetic for the slot currently addressed by idx.
    always_comb begin
        w_cur_speed = speed_q[idx_q];
        w_inc       = {1'b0, w_cur_speed} + C_ACCEL;
        w_speed_new = '0;
        w_sum       = '0;
        if (active_snap_q[idx_q]) begin
            if (thrust_snap_q[idx_q]) begin
                w_speed_new = (w_inc > C_SPEED_MAX) ? C_SPEED_MAX[SPEED_W-1:0]
                                                    : w_inc[SPEED_W-1:0];
            end else begin
                w_speed_new = (w_cur_speed >= C_DECEL) ? (w_cur_speed - C_DECEL) : '0;
            end
            w_sum = {1'b0, acc_q[idx_q]} + {1'b0, w_speed_new};
        end
        w_step = w_sum[SPEED_W];
        w_last = (idx_q == C_LAST_IDX);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        thrust_snap_d = thrust_snap_q;
        active_snap_d = active_snap_q;
        speed_d       = speed_q;
        acc_d         = acc_q;
        frame_done_d  = 1'b0;
        overrun_d     = overrun_q | (frame_tick & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    thrust_snap_d = thrust;
                    active_snap_d = obj_active;
                    idx_d         = '0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                speed_d[idx_q] = w_speed_new;
                acc_d[idx_q]   = w_sum[SPEED_W-1:0];
                if (w_step) begin
                    state_d = ST_ISSUE;
                end else if (w_last) begin
                    frame_done_d = 1'b1;
                    idx_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_ISSUE: begin
                if (upd_ready) begin
                    if (w_last) begin
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            thrust_snap_q <= '0;
            active_snap_q <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                speed_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            thrust_snap_q <= thrust_snap_d;
            active_snap_q <= active_snap_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            speed_q       <= speed_d;
            acc_q         <= acc_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_OBJ; g++) begin : g_flat
            assign speed_flat[g*SPEED_W +: SPEED_W] = speed_q[g];
        end
    endgenerate

    assign upd_valid  = (state_q == ST_ISSUE);
    assign upd_idx    = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motion_step_scheduler
//  Purpose  : Directed self-checking bench for motion_step_scheduler.
//  Revision : 1.0
// ============================================================================
module tb_motion_step_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [3:0]  thrust;
    logic [3:0]  obj_active;
    logic        upd_valid;
    logic [1:0]  upd_idx;
    logic        upd_ready;
    logic [39:0] speed_flat;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    motion_step_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .thrust     (thrust),
        .obj_active (obj_active),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_ready  (upd_ready),
        .speed_flat (speed_flat),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    function automatic int spd(input int i);
        return int'(speed_flat[i*10 +: 10]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: pulse the tick, then log accepted requests until frame_done.
    task automatic run_frame(input logic [3:0] act, input logic [3:0] thr,
                             output int nreq, output logic [7:0] lg);
        logic done;
        nreq = 0;
        lg   = '0;
        done = 1'b0;
        obj_active = act;
        thrust     = thr;
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (upd_valid && upd_ready) begin
                if (nreq < 4) lg[2*nreq +: 2] = upd_idx;
                nreq++;
            end
            if (frame_done) done = 1'b1;
            else @(negedge Clk);
        end
        check("frame_done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic prep();
        int nr, sum;
        logic [7:0] lg;
        sum = 0;
        upd_ready = 1'b1;
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            run_frame(4'b1111, 4'b1111, nr, lg);
            sum += nr;
        end
        check("prep_no_requests", 64'(sum), 64'd0);
        check("prep_speed0", 64'(spd(0)), 64'd88);
    endtask

    task automatic wait_issue(input logic [1:0] id);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            if (upd_valid && upd_idx == id) hit = 1'b1;
            else @(negedge Clk);
        end
        check("issue_wait", {63'd0, hit}, 64'd1);
    endtask

    initial begin
        int nr, fd, bs, exp;
        logic [7:0] lg;

        // T1: reset
        Reset = 1'b1; frame_tick = 1'b0; thrust = '0; obj_active = '0; upd_ready = 1'b1;
        repeat (3) @(negedge Clk);
        check("t1_valid", {63'd0, upd_valid}, 64'd0);
        check("t1_idx", 64'(upd_idx), 64'd0);
        check("t1_busy", {63'd0, busy}, 64'd0);
        check("t1_done", {63'd0, frame_done}, 64'd0);
        check("t1_overrun", {63'd0, overrun}, 64'd0);
        check("t1_speed", 64'(speed_flat), 64'd0);
        Reset = 1'b0;

        // T2: acceleration, first step on tick 23 (acc 1104 -> 80)
        for (int n = 1; n <= 23; n++) begin
            run_frame(4'b0001, 4'b0001, nr, lg);
            check("t2_speed", 64'(spd(0)), 64'(4 * n));
            if (n < 23) check("t2_no_req", 64'(nr), 64'd0);
        end
        check("t2_req_count", 64'(nr), 64'd1);
        check("t2_req_idx", 64'(lg[1:0]), 64'd0);
        check("t2_slot1_idle", 64'(spd(1)), 64'd0);

        // T3: saturation then decay to zero
        for (int n = 24; n <= 300; n++) begin
            run_frame(4'b0001, 4'b0001, nr, lg);
            exp = (4 * n > 1020) ? 1020 : 4 * n;
            check("t3_sat", 64'(spd(0)), 64'(exp));
        end
        for (int k = 1; k <= 1022; k++) begin
            run_frame(4'b0001, 4'b0000, nr, lg);
            exp = (k >= 1020) ? 0 : 1020 - k;
            check("t3_decay", 64'(spd(0)), 64'(exp));
        end

        // T4: stall in ISSUE; T5: tick dropped while busy
        prep();
        upd_ready = 1'b0;
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        @(negedge Clk);
        for (int c = 0; c < 5; c++) begin
            check("t4_valid", {63'd0, upd_valid}, 64'd1);
            check("t4_idx", 64'(upd_idx), 64'd0);
            check("t4_busy", {63'd0, busy}, 64'd1);
            check("t4_slot1_held", 64'(spd(1)), 64'd88);
            frame_tick = (c == 2);
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        check("t5_overrun_set", {63'd0, overrun}, 64'd1);
        upd_ready = 1'b1;
        nr = 0; lg = '0; fd = 0;
        for (int c = 0; c < 30 && fd == 0; c++) begin
            if (upd_valid && upd_ready) begin
                if (nr < 4) lg[2*nr +: 2] = upd_idx;
                nr++;
            end
            if (frame_done) fd++;
            else @(negedge Clk);
        end
        check("t5_frame_done", 64'(fd), 64'd1);
        check("t5_req_count", 64'(nr), 64'd4);
        check("t5_req_order", 64'(lg), 64'hE4);
        bs = 0; fd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (busy) bs++;
            if (frame_done) fd++;
        end
        check("t5_no_extra_scan", 64'(bs), 64'd0);
        check("t5_no_extra_done", 64'(fd), 64'd0);
        check("t5_overrun_sticky", {63'd0, overrun}, 64'd1);
        check("t5_slot3_speed", 64'(spd(3)), 64'd92);

        // T6a: mixed activity, slot 2 inactive
        prep();
        check("t6_overrun_cleared", {63'd0, overrun}, 64'd0);
        run_frame(4'b1011, 4'b1111, nr, lg);
        check("t6_req_count", 64'(nr), 64'd3);
        check("t6_req_order", 64'(lg[5:0]), 64'b11_01_00);
        check("t6_slot2_zero", 64'(spd(2)), 64'd0);
        check("t6_slot0", 64'(spd(0)), 64'd92);
        check("t6_slot3", 64'(spd(3)), 64'd92);
        @(negedge Clk);
        check("t6_done_single", {63'd0, frame_done}, 64'd0);

        // T6b: reset during the slot 1 request
        prep();
        upd_ready  = 1'b0;
        obj_active = 4'b1011;
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        wait_issue(2'd0);
        upd_ready = 1'b1;
        @(negedge Clk) upd_ready = 1'b0;
        wait_issue(2'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("t6r_valid", {63'd0, upd_valid}, 64'd0);
        check("t6r_idx", 64'(upd_idx), 64'd0);
        check("t6r_busy", {63'd0, busy}, 64'd0);
        check("t6r_done", {63'd0, frame_done}, 64'd0);
        check("t6r_overrun", {63'd0, overrun}, 64'd0);
        check("t6r_speed", 64'(speed_flat), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check("t6r_idle_after", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
